// File: rtl/accu_stream_pkg.sv
// -----------------------------------------------------------------------------
// accu_stream_pkg: width helpers, group-length clamp and sample extension.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package accu_stream_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_MAX_N  = 4;

  function automatic int unsigned calc_out_w(input int unsigned data_w,
                                             input int unsigned max_n);
    return data_w + $clog2(max_n);
  endfunction

  function automatic int unsigned calc_cnt_w(input int unsigned max_n);
    return $clog2(max_n + 1);
  endfunction

  // A length of 0 or anything beyond max_n selects the full group length.
  function automatic int unsigned clamp_n(input int unsigned cfg,
                                          input int unsigned max_n);
    return ((cfg == 0) || (cfg > max_n)) ? max_n : cfg;
  endfunction

  function automatic logic [63:0] ext(input logic [63:0] data,
                                      input int unsigned data_w,
                                      input bit          is_signed);
    logic [63:0] mask;
    mask = ~64'd0 << data_w;
    if (is_signed && data[data_w-1]) begin
      return data | mask;
    end
    return data & ~mask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/accu_out_slot.sv
// -----------------------------------------------------------------------------
// accu_out_slot: single-entry valid/ready output register (load, hold, drain).
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module accu_out_slot #(
  parameter int unsigned PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_load,
  input  logic [PAYLOAD_W-1:0] i_data,
  input  logic                 i_ready,
  output logic                 o_valid,
  output logic [PAYLOAD_W-1:0] o_data,
  output logic                 o_space
);

  logic                 r_valid;
  logic [PAYLOAD_W-1:0] r_data;

  // Space exists when empty or when the held entry drains this cycle.
  assign o_space = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/accu_stream_param.sv
// -----------------------------------------------------------------------------
// accu_stream_param: sums groups of up to MAX_N beats, one result per group.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module accu_stream_param
  import accu_stream_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned MAX_N  = DEF_MAX_N,
  parameter int unsigned SIGNED = 0,
  parameter int unsigned OUT_W  = calc_out_w(DATA_W, MAX_N),
  parameter int unsigned CNT_W  = calc_cnt_w(MAX_N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CNT_W-1:0]  cfg_n,
  input  logic              valid_a,
  output logic              ready_a,
  input  logic [DATA_W-1:0] data_in,
  input  logic              last_a,
  output logic              valid_b,
  input  logic              ready_b,
  output logic [OUT_W-1:0]  data_out,
  output logic [CNT_W-1:0]  cnt_out,
  output logic              early_out
);

  localparam int unsigned PAYLOAD_W = OUT_W + CNT_W + 1;

  logic [OUT_W-1:0]     r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     r_n_lat;

  logic [CNT_W-1:0]     w_cfg_clamped;
  logic [CNT_W-1:0]     w_eff_n;
  logic [CNT_W-1:0]     w_cnt_inc;
  logic [63:0]          w_ext_full;
  logic                 w_unused_ext;
  logic [OUT_W-1:0]     w_sample;
  logic [OUT_W-1:0]     w_sum;
  logic                 w_accept;
  logic                 w_final;
  logic                 w_early;
  logic                 w_space;
  logic [PAYLOAD_W-1:0] w_payload_in;
  logic [PAYLOAD_W-1:0] w_payload_out;

  assign w_cfg_clamped = CNT_W'(clamp_n(32'(cfg_n), MAX_N));
  // The first beat of a group sees the live length; later beats the latched one.
  assign w_eff_n       = (r_cnt == '0) ? w_cfg_clamped : r_n_lat;
  assign w_cnt_inc     = r_cnt + CNT_W'(1);

  assign w_ext_full    = ext(64'(data_in), DATA_W, SIGNED != 0);
  assign w_sample      = w_ext_full[OUT_W-1:0];
  assign w_unused_ext  = ^w_ext_full[63:OUT_W];
  assign w_sum         = r_acc + w_sample;

  assign ready_a       = w_space;
  assign w_accept      = valid_a && w_space;
  assign w_final       = w_accept && ((w_cnt_inc == w_eff_n) || last_a);
  assign w_early       = last_a && (w_cnt_inc != w_eff_n);
  assign w_payload_in  = {w_sum, w_cnt_inc, w_early};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_n_lat <= CNT_W'(MAX_N);
    end else if (w_accept) begin
      if (r_cnt == '0) begin
        r_n_lat <= w_cfg_clamped;
      end
      if (w_final) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_sum;
        r_cnt <= w_cnt_inc;
      end
    end
  end

  accu_out_slot #(
    .PAYLOAD_W (PAYLOAD_W)
  ) u_out_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_final),
    .i_data  (w_payload_in),
    .i_ready (ready_b),
    .o_valid (valid_b),
    .o_data  (w_payload_out),
    .o_space (w_space)
  );

  assign data_out  = w_payload_out[PAYLOAD_W-1 -: OUT_W];
  assign cnt_out   = w_payload_out[CNT_W:1];
  assign early_out = w_payload_out[0];

endmodule

`default_nettype wire

// File: tb/tb_accu_stream_param.sv
// -----------------------------------------------------------------------------
// tb_accu_stream_param: unsigned and signed instances against a group-sum model.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_accu_stream_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] cfg_n = 3'd4;
  logic       valid_a = 1'b0;
  logic [7:0] data_in = 8'd0;
  logic       last_a = 1'b0;
  logic       ready_b = 1'b1;

  logic       u_ready_a, u_valid_b, u_early;
  logic [9:0] u_data_out;
  logic [2:0] u_cnt_out;
  logic       s_ready_a, s_valid_b, s_early;
  logic [9:0] s_data_out;
  logic [2:0] s_cnt_out;

  int errors = 0;
  int checks = 0;
  bit rnd_ready = 0;

  typedef struct {
    int usum;
    int ssum;
    int cnt;
    bit early;
  } exp_t;

  exp_t q[$];
  int   m_cnt = 0;
  int   m_n = 4;
  int   m_usum = 0;
  int   m_ssum = 0;

  always #5 clk = ~clk;

  accu_stream_param #(.DATA_W(8), .MAX_N(4), .SIGNED(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_n(cfg_n), .valid_a(valid_a), .ready_a(u_ready_a),
    .data_in(data_in), .last_a(last_a), .valid_b(u_valid_b), .ready_b(ready_b),
    .data_out(u_data_out), .cnt_out(u_cnt_out), .early_out(u_early)
  );

  accu_stream_param #(.DATA_W(8), .MAX_N(4), .SIGNED(1)) s_dut (
    .clk(clk), .rst_n(rst_n), .cfg_n(cfg_n), .valid_a(valid_a), .ready_a(s_ready_a),
    .data_in(data_in), .last_a(last_a), .valid_b(s_valid_b), .ready_b(ready_b),
    .data_out(s_data_out), .cnt_out(s_cnt_out), .early_out(s_early)
  );

  // One clock step: observe at the falling edge, update the group model, return at posedge+1.
  task automatic tick(output bit acc);
    exp_t e;
    bit   exp_valid;
    acc = 0;
    @(negedge clk);
    if (!rst_n) begin
      m_cnt = 0; m_usum = 0; m_ssum = 0;
      q.delete();
    end else begin
      exp_valid = (q.size() != 0);
      checks++;
      if (u_valid_b !== exp_valid || s_valid_b !== exp_valid ||
          u_ready_a !== (!exp_valid || ready_b) || s_ready_a !== (!exp_valid || ready_b)) begin
        errors++;
        $display("FAIL handshake t=%0t: valid u/s=%b/%b ready_a u/s=%b/%b, want valid=%b ready_a=%b",
                 $time, u_valid_b, s_valid_b, u_ready_a, s_ready_a, exp_valid, !exp_valid || ready_b);
      end
      if (u_valid_b && ready_b && exp_valid) begin
        e = q.pop_front();
        checks++;
        if (u_data_out !== 10'(e.usum) || s_data_out !== 10'(e.ssum) ||
            u_cnt_out !== 3'(e.cnt) || s_cnt_out !== 3'(e.cnt) ||
            u_early !== e.early || s_early !== e.early) begin
          errors++;
          $display("FAIL result t=%0t: u=%0d s=%h cnt=%0d early=%b, want u=%0d s=%h cnt=%0d early=%b",
                   $time, u_data_out, s_data_out, u_cnt_out, u_early,
                   10'(e.usum), 10'(e.ssum), e.cnt, e.early);
        end
      end
      if (valid_a && u_ready_a) begin
        acc = 1;
        if (m_cnt == 0) m_n = (cfg_n == 0 || cfg_n > 4) ? 4 : int'(cfg_n);
        m_usum += int'(data_in);
        m_ssum += int'($signed(data_in));
        m_cnt++;
        if (m_cnt == m_n || last_a) begin
          e.usum = m_usum; e.ssum = m_ssum; e.cnt = m_cnt; e.early = last_a && (m_cnt != m_n);
          q.push_back(e);
          m_cnt = 0; m_usum = 0; m_ssum = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int k = 0; k < n; k++) begin
      if (rnd_ready) ready_b = ($urandom_range(0, 3) != 0);
      tick(a);
    end
  endtask

  task automatic send(input logic [7:0] d, input bit l);
    bit a;
    bit ok;
    ok = 0;
    valid_a = 1'b1; data_in = d; last_a = l;
    for (int k = 0; k < 64; k++) begin
      if (rnd_ready) ready_b = ($urandom_range(0, 3) != 0);
      tick(a);
      if (a) begin ok = 1; break; end
    end
    if (!ok) begin
      errors++; checks++;
      $display("FAIL send_timeout: beat %0d never accepted, want accepted within 64 cycles", d);
    end
    valid_a = 1'b0; last_a = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (u_valid_b !== 1'b0 || u_data_out !== 10'd0 || u_cnt_out !== 3'd0 || u_early !== 1'b0 ||
        u_ready_a !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: valid=%b data=%0d cnt=%0d early=%b ready_a=%b, want 0/0/0/0/1",
               u_valid_b, u_data_out, u_cnt_out, u_early, u_ready_a);
    end
    idle(2);
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_basic();
    cfg_n = 3'd4; ready_b = 1'b1;
    send(8'd10, 0); send(8'd20, 0); send(8'd30, 0);
    checks++;
    if (u_valid_b !== 1'b0) begin
      errors++; $display("FAIL basic_early_valid: valid=%b, want 0 before 4th beat", u_valid_b);
    end
    send(8'd40, 0);
    checks++;
    if (u_valid_b !== 1'b1 || u_data_out !== 10'd100 || u_cnt_out !== 3'd4 || u_early !== 1'b0) begin
      errors++;
      $display("FAIL basic_sum: valid=%b data=%0d cnt=%0d early=%b, want 1/100/4/0",
               u_valid_b, u_data_out, u_cnt_out, u_early);
    end
    idle(2);
  endtask

  task automatic test_full_scale();
    cfg_n = 3'd4;
    for (int k = 0; k < 4; k++) send(8'hFF, 0);
    checks++;
    if (u_data_out !== 10'd1020 || s_data_out !== 10'h3FC) begin
      errors++;
      $display("FAIL full_scale: u=%0d s=%h, want u=1020 s=3fc", u_data_out, s_data_out);
    end
    idle(1);
  endtask

  task automatic test_signed();
    cfg_n = 3'd3;
    send(8'hFF, 0); send(8'hFE, 0); send(8'h05, 0);
    checks++;
    if (s_data_out !== 10'd2 || s_cnt_out !== 3'd3 || u_data_out !== 10'd514) begin
      errors++;
      $display("FAIL signed_sum: s=%0d cnt=%0d u=%0d, want s=2 cnt=3 u=514", s_data_out, s_cnt_out, u_data_out);
    end
    idle(1);
  endtask

  task automatic test_early_close();
    cfg_n = 3'd4;
    send(8'd7, 0); send(8'd8, 1);
    checks++;
    if (u_data_out !== 10'd15 || u_cnt_out !== 3'd2 || u_early !== 1'b1) begin
      errors++;
      $display("FAIL early_close: data=%0d cnt=%0d early=%b, want 15/2/1", u_data_out, u_cnt_out, u_early);
    end
    send(8'd1, 0); send(8'd2, 0); send(8'd3, 0); send(8'd4, 0);
    checks++;
    if (u_data_out !== 10'd10 || u_cnt_out !== 3'd4 || u_early !== 1'b0) begin
      errors++;
      $display("FAIL after_early: data=%0d cnt=%0d early=%b, want 10/4/0", u_data_out, u_cnt_out, u_early);
    end
    cfg_n = 3'd2;
    send(8'd3, 0); send(8'd4, 1);
    checks++;
    if (u_data_out !== 10'd7 || u_cnt_out !== 3'd2 || u_early !== 1'b0) begin
      errors++;
      $display("FAIL last_at_len: data=%0d cnt=%0d early=%b, want 7/2/0", u_data_out, u_cnt_out, u_early);
    end
    idle(1);
  endtask

  task automatic test_backpressure();
    bit  a;
    time t0;
    cfg_n = 3'd2; ready_b = 1'b1;
    send(8'd1, 0); send(8'd2, 0);
    ready_b = 1'b0;
    valid_a = 1'b1; data_in = 8'd3;
    for (int k = 0; k < 4; k++) begin
      tick(a);
      checks++;
      if (a || u_ready_a !== 1'b0 || u_valid_b !== 1'b1 || u_data_out !== 10'd3 || u_cnt_out !== 3'd2) begin
        errors++;
        $display("FAIL stall_hold: accepted=%b ready_a=%b valid=%b data=%0d cnt=%0d, want 0/0/1/3/2",
                 a, u_ready_a, u_valid_b, u_data_out, u_cnt_out);
      end
    end
    ready_b = 1'b1;
    t0 = $time;
    send(8'd3, 0); send(8'd4, 0); send(8'd5, 0); send(8'd6, 0);
    checks++;
    if (($time - t0) != 40 || u_data_out !== 10'd11) begin
      errors++;
      $display("FAIL no_bubble: elapsed=%0t data=%0d, want 40 and 11", $time - t0, u_data_out);
    end
    cfg_n = 3'd1;
    for (int k = 0; k < 4; k++) begin
      send(8'(8'hF0 + k), 0);
      checks++;
      if (u_valid_b !== 1'b1 || u_data_out !== 10'(240 + k) || s_data_out !== 10'(1024 - 16 + k)) begin
        errors++;
        $display("FAIL passthrough: valid=%b u=%0d s=%h, want 1 u=%0d s=%h",
                 u_valid_b, u_data_out, s_data_out, 240 + k, 10'(1024 - 16 + k));
      end
    end
    idle(1);
  endtask

  task automatic test_cfg_change_and_reset();
    cfg_n = 3'd0;
    send(8'd1, 0); send(8'd2, 0);
    cfg_n = 3'd2;
    send(8'd3, 0); send(8'd4, 0);
    checks++;
    if (u_data_out !== 10'd10 || u_cnt_out !== 3'd4) begin
      errors++; $display("FAIL cfg_midgroup: data=%0d cnt=%0d, want 10/4", u_data_out, u_cnt_out);
    end
    send(8'd5, 0); send(8'd6, 0);
    checks++;
    if (u_data_out !== 10'd11 || u_cnt_out !== 3'd2) begin
      errors++; $display("FAIL cfg_next: data=%0d cnt=%0d, want 11/2", u_data_out, u_cnt_out);
    end
    idle(1);
    cfg_n = 3'd4;
    send(8'd9, 0); send(8'd9, 0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (u_valid_b !== 1'b0 || u_data_out !== 10'd0) begin
      errors++; $display("FAIL reset_midgroup: valid=%b data=%0d, want 0/0", u_valid_b, u_data_out);
    end
    idle(2);
    rst_n = 1'b1;
    idle(3);
    cfg_n = 3'd1;
    send(8'd1, 0);
    checks++;
    if (u_data_out !== 10'd1 || u_cnt_out !== 3'd1) begin
      errors++; $display("FAIL partial_discard: data=%0d cnt=%0d, want 1/1", u_data_out, u_cnt_out);
    end
    idle(1);
  endtask

  task automatic test_random();
    rnd_ready = 1;
    for (int i = 0; i < 300; i++) begin
      cfg_n = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 4) == 0) idle(1);
      else send(8'($urandom), $urandom_range(0, 5) == 0);
    end
    rnd_ready = 0;
    ready_b = 1'b1;
    idle(3);
    checks++;
    if (q.size() != 0 || u_valid_b !== 1'b0) begin
      errors++; $display("FAIL drain: pending=%0d valid=%b, want 0/0", q.size(), u_valid_b);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_scale();
    test_signed();
    test_early_close();
    test_backpressure();
    test_cfg_change_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
